shift_sub_divider: RTL and testbench
====================================

// Module: shift_sub_divider
// PURPOSE
//  Sequential restoring divider, the inverse of the shift-add multiplier: N-bit
//  unsigned Dividend / N-bit Divisor -> N-bit Quotient + N-bit Remainder.
//  An internal FSM (Idle/Shift/Subtract/Done) drives a shift-subtract datapath,
//  one quotient bit per two clocks. Sits beside the multiplier in the
//  arithmetic unit with the same St/Idle/Done start-complete handshake.
// PARAMETERS
//  N      8    operand width (Dividend, Divisor, Quotient, Remainder); N >= 2
// PORTS
//  Clk        in   1   system clock, rising edge
//  Rst        in   1   asynchronous, active-high reset
//  St         in   1   start request, sampled only in S0
//  Dividend   in   N   unsigned dividend, captured on accept
//  Divisor    in   N   unsigned divisor, captured on accept
//  Quotient   out  N   quotient; valid while Done=1, held until next accept
//  Remainder  out  N   remainder; valid while Done=1, held until next accept
//  Idle       out  1   1 in S0 (combinational from state)
//  Done       out  1   1-cycle pulse in S3
//  DivZ       out  1   divide-by-zero flag; set on accept, held until next accept
// BEHAVIOUR
//  - Reset: state=S0, P=0, Qr=0, cnt=0, DivZ=0 => Idle=1, Done=0, Quotient=0,
//    Remainder=0. Rst mid-operation aborts immediately; no Done is issued.
//  - Registers: P (N+1 b) partial remainder, Qr (N b) dividend/quotient,
//    D (N b) divisor, cnt (log2(N)+1 b) bit counter. Quotient=Qr, Remainder=P[N-1:0].
//  - S0 (Idle=1): on St=1 at the clock edge: D<=Divisor, DivZ<=(Divisor==0).
//    Divisor!=0: P<=0, Qr<=Dividend, cnt<=0, -> S1.
//    Divisor==0: Qr<={N{1'b1}}, P<={1'b0,Dividend}, -> S3.
//    St=0: stay in S0, all registers hold.
//  - S1 Shift: {P,Qr}<={P,Qr}<<1 (Qr[0]<=0); -> S2.
//  - S2 Subtract: diff=(N+2)b {1'b0,P}-{2'b0,D}. diff[N+1]==0: P<=diff[N:0],
//    Qr[0]<=1; else P and Qr[0] hold (restore). cnt<=cnt+1;
//    -> S3 if cnt==N-1 (K condition), else -> S1.
//  - S3 Done=1 for exactly one cycle; -> S0. Results held until next accept.
//  - Latency: accept edge E0; Done=1 in cycle after edge E0+2N (2N+1 clocks
//    from accept); divide-by-zero: Done in cycle after E0 (1 clock).
//  - St while not in S0 is ignored (no queueing). St held high continuously
//    gives back-to-back ops: S3->S0->accept on the next edge.
//  - Operand inputs are sampled only on the accept edge; later changes ignored.
//  - Unused state encodings -> S0 on next edge (default branch).
//  - No overflow: N/N division always fits; P MSB absorbs the shifted-out bit.
// STRUCTURE
//  - Shared package div_pkg: state constants S0..S3 (2-bit encoding 0..3),
//    shared with the multiplier control encoding.
//  - One sub-module: div_control (FSM only: inputs Clk, Rst, St, K, Z;
//    outputs Idle, Done, Load, Sh, Su, LoadZ), mirroring multiplier control.
//    Top level holds P/Qr/D/cnt datapath, comparator and K=(cnt==N-1).
//  - Datapath registers use the same async Rst as the FSM.
// TESTING (N=8)
//  - 100/7: St 1 clk -> Done after 17 clks, Quotient=14, Remainder=2, DivZ=0.
//  - 255/1 -> Quotient=255, Remainder=0; 5/9 -> Quotient=0, Remainder=5;
//    255/255 -> Quotient=1, Remainder=0.
//  - 200/0 -> Done 1 clk after accept, DivZ=1, Quotient=8'hFF, Remainder=200;
//    following 9/3 -> DivZ=0, Quotient=3, Remainder=0.
//  - Rst pulse 5 clks into 100/7 -> Idle=1, Quotient=Remainder=0 at once, no
//    Done; then 50/6 -> Quotient=8, Remainder=2.
//  - St held high over three ops; operands changed mid-op -> each result
//    matches the operands at its accept edge; one Done per op, 18 clks apart.
//  - Random 1000 pairs vs reference model a/b, a%b; Done width always 1 clk.

Source files
------------

// File: rtl/div_pkg.sv
// Shared control-state encoding for the shift-sub divider; the multiplier control uses the same encoding.
package div_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/div_control.sv
// Divider control FSM: Idle/Shift/Subtract/Done sequencing with the start/complete handshake.
module div_control
  import div_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic St,
  input  logic K,
  input  logic Z,
  output logic Idle,
  output logic Done,
  output logic Load,
  output logic Sh,
  output logic Su,
  output logic LoadZ
);

  state_t state_reg, state_next;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= S0;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    Idle       = 1'b0;
    Done       = 1'b0;
    Load       = 1'b0;
    Sh         = 1'b0;
    Su         = 1'b0;
    LoadZ      = 1'b0;
    case (state_reg)
      S0: begin
        Idle = 1'b1;
        if (St) begin
          // A zero divisor skips the iterations and goes straight to Done.
          if (Z) begin
            LoadZ      = 1'b1;
            state_next = S3;
          end else begin
            Load       = 1'b1;
            state_next = S1;
          end
        end
      end
      S1: begin
        Sh         = 1'b1;
        state_next = S2;
      end
      S2: begin
        Su         = 1'b1;
        state_next = K ? S3 : S1;
      end
      S3: begin
        Done       = 1'b1;
        state_next = S0;
      end
      default: state_next = S0;
    endcase
  end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: N-bit unsigned Dividend / Divisor, one quotient bit per two clocks.
module shift_sub_divider
  import div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         St,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         Idle,
  output logic         Done,
  output logic         DivZ
);

  localparam int            CW       = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [N:0]    p_reg, p_next;
  logic [N-1:0]  qr_reg, qr_next;
  logic [N-1:0]  d_reg, d_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          divz_reg, divz_next;

  logic          load, sh, su, load_z;
  logic          k_last, z_div;
  logic [N+1:0]  diff;

  assign z_div  = (Divisor == '0);
  assign k_last = (cnt_reg == CNT_LAST);
  // One extra bit so the borrow shows up as the sign of the difference.
  assign diff   = {1'b0, p_reg} - {2'b00, d_reg};

  div_control u_ctrl (
    .Clk   (Clk),
    .Rst   (Rst),
    .St    (St),
    .K     (k_last),
    .Z     (z_div),
    .Idle  (Idle),
    .Done  (Done),
    .Load  (load),
    .Sh    (sh),
    .Su    (su),
    .LoadZ (load_z)
  );

  always_comb begin
    p_next    = p_reg;
    qr_next   = qr_reg;
    d_next    = d_reg;
    cnt_next  = cnt_reg;
    divz_next = divz_reg;
    if (load) begin
      d_next    = Divisor;
      divz_next = 1'b0;
      p_next    = '0;
      qr_next   = Dividend;
      cnt_next  = '0;
    end else if (load_z) begin
      // Divide-by-zero convention: all-ones quotient, dividend as remainder.
      d_next    = Divisor;
      divz_next = 1'b1;
      p_next    = {1'b0, Dividend};
      qr_next   = '1;
    end else if (sh) begin
      {p_next, qr_next} = {p_reg[N-1:0], qr_reg, 1'b0};
    end else if (su) begin
      if (!diff[N+1]) begin
        p_next     = diff[N:0];
        qr_next[0] = 1'b1;
      end
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      p_reg    <= '0;
      qr_reg   <= '0;
      d_reg    <= '0;
      cnt_reg  <= '0;
      divz_reg <= 1'b0;
    end else begin
      p_reg    <= p_next;
      qr_reg   <= qr_next;
      d_reg    <= d_next;
      cnt_reg  <= cnt_next;
      divz_reg <= divz_next;
    end
  end

  assign Quotient  = qr_reg;
  assign Remainder = p_reg[N-1:0];
  assign DivZ      = divz_reg;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider (N=8): results, latency, divide-by-zero, abort and back-to-back ops.
module tb_shift_sub_divider;

  localparam int N = 8;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         St;
  logic [N-1:0] Dividend;
  logic [N-1:0] Divisor;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         Idle;
  logic         Done;
  logic         DivZ;

  int asserts = 0;
  int errors  = 0;

  logic [7:0] vec_a [0:9] = '{8'd255, 8'd5, 8'd255, 8'd0, 8'd1, 8'd128, 8'd254, 8'd77, 8'd255, 8'd171};
  logic [7:0] vec_b [0:9] = '{8'd1,   8'd9, 8'd255, 8'd5, 8'd1, 8'd3,   8'd16,  8'd255, 8'd2,  8'd10};
  logic [7:0] vec_q [0:9] = '{8'd255, 8'd0, 8'd1,   8'd0, 8'd1, 8'd42,  8'd15,  8'd0,  8'd127, 8'd17};
  logic [7:0] vec_r [0:9] = '{8'd0,   8'd5, 8'd0,   8'd0, 8'd0, 8'd2,   8'd14,  8'd77, 8'd1,   8'd1};

  always #5 Clk = ~Clk;

  shift_sub_divider #(.N(N)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .St        (St),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Idle      (Idle),
    .Done      (Done),
    .DivZ      (DivZ)
  );

  // Called 1 time unit after a rising edge; returns in the Done cycle (or after the bound).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    St = 1'b1; Dividend = a; Divisor = b;
    @(posedge Clk); #1;
    St = 1'b0;
    lat = 0;
    while (Done !== 1'b1 && lat < 100) begin
      @(posedge Clk); #1;
      lat++;
    end
    $display("op %0d / %0d -> quotient %0d remainder %0d divz %0b after %0d clocks",
             a, b, Quotient, Remainder, DivZ, lat);
  endtask

  task automatic test_reset;
    Rst = 1'b1; St = 1'b0; Dividend = 8'd123; Divisor = 8'd45;
    repeat (2) @(posedge Clk);
    #1;
    asserts++; if (Idle !== 1'b1)       begin errors++; $display("FAIL reset_idle: got %b expected 1", Idle); end
    asserts++; if (Done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
    asserts++; if (Quotient !== 8'd0)   begin errors++; $display("FAIL reset_quotient: got %0d expected 0", Quotient); end
    asserts++; if (Remainder !== 8'd0)  begin errors++; $display("FAIL reset_remainder: got %0d expected 0", Remainder); end
    asserts++; if (DivZ !== 1'b0)       begin errors++; $display("FAIL reset_divz: got %b expected 0", DivZ); end
    Rst = 1'b0;
    @(posedge Clk); #1;
    $display("reset released");
  endtask

  // 100/7 with a stray St pulse and operand changes mid-operation.
  task automatic test_basic;
    int lat;
    St = 1'b1; Dividend = 8'd100; Divisor = 8'd7;
    @(posedge Clk); #1;
    St = 1'b0; Dividend = 8'd3; Divisor = 8'd1;
    lat = 0;
    while (Done !== 1'b1 && lat < 100) begin
      @(posedge Clk); #1;
      lat++;
      if (lat == 5) St = 1'b1;
      if (lat == 6) St = 1'b0;
    end
    $display("op 100 / 7 -> quotient %0d remainder %0d divz %0b after %0d clocks", Quotient, Remainder, DivZ, lat);
    asserts++; if (lat !== 16)          begin errors++; $display("FAIL basic_latency: got %0d expected 16", lat); end
    asserts++; if (Quotient !== 8'd14)  begin errors++; $display("FAIL basic_quotient: got %0d expected 14", Quotient); end
    asserts++; if (Remainder !== 8'd2)  begin errors++; $display("FAIL basic_remainder: got %0d expected 2", Remainder); end
    asserts++; if (DivZ !== 1'b0)       begin errors++; $display("FAIL basic_divz: got %b expected 0", DivZ); end
    asserts++; if (Idle !== 1'b0)       begin errors++; $display("FAIL basic_idle_in_done: got %b expected 0", Idle); end
    @(posedge Clk); #1;
    asserts++; if (Done !== 1'b0)       begin errors++; $display("FAIL basic_done_width: got %b expected 0", Done); end
    asserts++; if (Idle !== 1'b1)       begin errors++; $display("FAIL basic_idle_after: got %b expected 1", Idle); end
    repeat (3) @(posedge Clk);
    #1;
    asserts++; if (Quotient !== 8'd14 || Remainder !== 8'd2) begin
      errors++; $display("FAIL basic_hold: got %0d/%0d expected 14/2", Quotient, Remainder);
    end
  endtask

  task automatic test_vectors;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(vec_a[i], vec_b[i], lat);
      asserts++; if (lat !== 16)            begin errors++; $display("FAIL vec%0d_latency: got %0d expected 16", i, lat); end
      asserts++; if (Quotient !== vec_q[i]) begin errors++; $display("FAIL vec%0d_quotient: got %0d expected %0d", i, Quotient, vec_q[i]); end
      asserts++; if (Remainder !== vec_r[i]) begin errors++; $display("FAIL vec%0d_remainder: got %0d expected %0d", i, Remainder, vec_r[i]); end
      asserts++; if (DivZ !== 1'b0)         begin errors++; $display("FAIL vec%0d_divz: got %b expected 0", i, DivZ); end
      @(posedge Clk); #1;
      asserts++; if (Done !== 1'b0)         begin errors++; $display("FAIL vec%0d_done_width: got %b expected 0", i, Done); end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    run_op(8'd200, 8'd0, lat);
    asserts++; if (lat !== 0)            begin errors++; $display("FAIL divz_latency: got %0d expected 0", lat); end
    asserts++; if (DivZ !== 1'b1)        begin errors++; $display("FAIL divz_flag: got %b expected 1", DivZ); end
    asserts++; if (Quotient !== 8'hFF)   begin errors++; $display("FAIL divz_quotient: got %0d expected 255", Quotient); end
    asserts++; if (Remainder !== 8'd200) begin errors++; $display("FAIL divz_remainder: got %0d expected 200", Remainder); end
    @(posedge Clk); #1;
    asserts++; if (Done !== 1'b0)        begin errors++; $display("FAIL divz_done_width: got %b expected 0", Done); end
    asserts++; if (DivZ !== 1'b1)        begin errors++; $display("FAIL divz_flag_hold: got %b expected 1", DivZ); end
    asserts++; if (Idle !== 1'b1)        begin errors++; $display("FAIL divz_idle_after: got %b expected 1", Idle); end
    run_op(8'd9, 8'd3, lat);
    asserts++; if (lat !== 16)           begin errors++; $display("FAIL after_divz_latency: got %0d expected 16", lat); end
    asserts++; if (DivZ !== 1'b0)        begin errors++; $display("FAIL after_divz_flag: got %b expected 0", DivZ); end
    asserts++; if (Quotient !== 8'd3)    begin errors++; $display("FAIL after_divz_quotient: got %0d expected 3", Quotient); end
    asserts++; if (Remainder !== 8'd0)   begin errors++; $display("FAIL after_divz_remainder: got %0d expected 0", Remainder); end
    @(posedge Clk); #1;
  endtask

  task automatic test_abort;
    int lat;
    int dones;
    St = 1'b1; Dividend = 8'd100; Divisor = 8'd7;
    @(posedge Clk); #1;
    St = 1'b0;
    repeat (5) @(posedge Clk);
    #3;
    Rst = 1'b1;
    #1;
    asserts++; if (Idle !== 1'b1)      begin errors++; $display("FAIL abort_idle: got %b expected 1", Idle); end
    asserts++; if (Done !== 1'b0)      begin errors++; $display("FAIL abort_done: got %b expected 0", Done); end
    asserts++; if (Quotient !== 8'd0 || Remainder !== 8'd0) begin
      errors++; $display("FAIL abort_clear: got %0d/%0d expected 0/0", Quotient, Remainder);
    end
    @(posedge Clk); #1;
    Rst = 1'b0;
    $display("op 100 / 7 aborted by reset");
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge Clk); #1;
      if (Done === 1'b1) dones++;
    end
    asserts++; if (dones !== 0)        begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
    run_op(8'd50, 8'd6, lat);
    asserts++; if (lat !== 16)         begin errors++; $display("FAIL abort_next_latency: got %0d expected 16", lat); end
    asserts++; if (Quotient !== 8'd8)  begin errors++; $display("FAIL abort_next_quotient: got %0d expected 8", Quotient); end
    asserts++; if (Remainder !== 8'd2) begin errors++; $display("FAIL abort_next_remainder: got %0d expected 2", Remainder); end
    @(posedge Clk); #1;
  endtask

  // St held high across three ops; operand inputs change while each op runs.
  task automatic test_back_to_back;
    int         n_done;
    int         wide;
    logic       prev_done;
    int         done_c [0:3];
    logic [7:0] got_q  [0:3];
    logic [7:0] got_r  [0:3];
    logic [7:0] exp_q  [0:2] = '{8'd3, 8'd15, 8'd15};
    logic [7:0] exp_r  [0:2] = '{8'd1, 8'd5,  8'd15};
    int         exp_c  [0:2] = '{16, 34, 52};
    n_done = 0; wide = 0; prev_done = 1'b0;
    St = 1'b1; Dividend = 8'd10; Divisor = 8'd3;
    for (int c = 0; c < 60; c++) begin
      @(posedge Clk); #1;
      if (Done === 1'b1) begin
        if (prev_done) wide++;
        if (n_done < 4) begin
          done_c[n_done] = c; got_q[n_done] = Quotient; got_r[n_done] = Remainder;
        end
        $display("back-to-back op %0d done at clock %0d: quotient %0d remainder %0d", n_done, c, Quotient, Remainder);
        n_done++;
      end
      prev_done = (Done === 1'b1);
      if (c == 1)  begin Dividend = 8'd99;  Divisor = 8'd99; end
      if (c == 10) begin Dividend = 8'd200; Divisor = 8'd13; end
      if (c == 19) begin Dividend = 8'd77;  Divisor = 8'd88; end
      if (c == 25) begin Dividend = 8'd255; Divisor = 8'd16; end
      if (c == 40) begin St = 1'b0; Dividend = 8'd1; Divisor = 8'd1; end
    end
    asserts++; if (n_done !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", n_done); end
    asserts++; if (wide !== 0)   begin errors++; $display("FAIL b2b_done_width: got %0d wide pulses expected 0", wide); end
    for (int k = 0; k < n_done && k < 3; k++) begin
      asserts++; if (done_c[k] !== exp_c[k]) begin errors++; $display("FAIL b2b%0d_clock: got %0d expected %0d", k, done_c[k], exp_c[k]); end
      asserts++; if (got_q[k] !== exp_q[k])  begin errors++; $display("FAIL b2b%0d_quotient: got %0d expected %0d", k, got_q[k], exp_q[k]); end
      asserts++; if (got_r[k] !== exp_r[k])  begin errors++; $display("FAIL b2b%0d_remainder: got %0d expected %0d", k, got_r[k], exp_r[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
